// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Sequences a UART receiver (start / listen / drain-on-halt) and buffers
//   good bytes in a small first-word-fall-through FIFO. Framing errors are
//   counted (saturating). A dropped good byte sets a sticky overrun flag.
//
//   Optional feature macro: UART_RX_CTRL_TIMEOUT_EN
//     When defined, an idle counter runs in LISTEN while the receiver is not
//     mid-frame. It pulses timeout_o every TIMEOUT_CYCLES idle clocks.
//     When undefined, timeout_o is tied low and TIMEOUT_CYCLES is unused.
//
//   Ports
//     clk_i, rst_i          clock, asynchronous active-high reset
//     go_i, halt_i          start / stop pulses
//     rx_en_o               receiver enable
//     rx_busy_i             receiver mid-frame
//     rx_done_i             frame-complete strobe
//     rx_error_i            framing error (qualified by rx_done_i)
//     rx_data_i             received byte
//     rd_en_i               consumer pop request
//     rd_data_o             FIFO head (holds last head while empty)
//     empty_o, full_o       FIFO status
//     count_o               bytes held
//     overrun_o             sticky: good byte dropped on a full FIFO
//     err_cnt_o             saturating framing-error count
//     active_o              high in ARM, LISTEN or DRAIN
//     timeout_o             one-cycle idle-timeout pulse
//
//   state  | meaning
//   IDLE   | receiver off, waiting for go
//   ARM    | receiver enabled for one settling cycle
//   LISTEN | capturing frames
//   DRAIN  | halt requested mid-frame; finish that frame, then stop
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1600
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         go_i,
  input  logic                         halt_i,
  output logic                         rx_en_o,
  input  logic                         rx_busy_i,
  input  logic                         rx_done_i,
  input  logic                         rx_error_i,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rd_en_i,
  output logic [7:0]                   rd_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic                         overrun_o,
  output logic [7:0]                   err_cnt_o,
  output logic                         active_o,
  output logic                         timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARM, LISTEN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          overrun_q, overrun_d;
  logic          clear_stats, capture, good_byte, bad_byte, fifo_full, push, pop;

  always_comb begin
    state_d     = state_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE: begin
        // halt wins over a simultaneous go
        if (go_i && !halt_i) begin
          state_d     = ARM;
          clear_stats = 1'b1;
        end
      end
      ARM:     state_d = LISTEN;
      LISTEN:  if (halt_i) state_d = rx_busy_i ? DRAIN : IDLE;
      DRAIN:   if (rx_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rx_en_o  = (state_q != IDLE);
  assign active_o = (state_q != IDLE);

  assign capture   = rx_done_i && (state_q == LISTEN || state_q == DRAIN);
  assign good_byte = capture && !rx_error_i;
  assign bad_byte  = capture && rx_error_i;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = rd_en_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push      = good_byte && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    overrun_d = clear_stats ? 1'b0 : (overrun_q | (good_byte && fifo_full && !pop));
    err_cnt_d = err_cnt_q;
    if (clear_stats)
      err_cnt_d = 8'h00;
    else if (bad_byte && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
    // Registered head: follows the next head slot, or the incoming byte when
    // that byte becomes the only entry; holds when the FIFO goes empty.
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      if (push && (count_q == CW'(pop)))
        rd_data_d = rx_data_i;
      else
        rd_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
      err_cnt_q <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      err_cnt_q <= err_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_data_i;
  end

  assign rd_data_o = rd_data_q;
  assign empty_o   = (count_q == '0);
  assign full_o    = fifo_full;
  assign count_o   = count_q;
  assign overrun_o = overrun_q;
  assign err_cnt_o = err_cnt_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;

  // Counter is forced to zero outside LISTEN, so every LISTEN entry starts fresh
  always_comb begin
    idle_d    = '0;
    timeout_d = 1'b0;
    if (state_q == LISTEN && !rx_busy_i) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1))
        timeout_d = 1'b1;
      else
        idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, go, halt, rx_busy, rx_done, rx_error, rd_en;
  logic [7:0] rx_data;
  logic       rx_en, empty, full, overrun, active, timeout;
  logic [7:0] rd_data, err_cnt;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(20)) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .halt_i(halt), .rx_en_o(rx_en),
    .rx_busy_i(rx_busy), .rx_done_i(rx_done), .rx_error_i(rx_error),
    .rx_data_i(rx_data), .rd_en_i(rd_en), .rd_data_o(rd_data),
    .empty_o(empty), .full_o(full), .count_o(count), .overrun_o(overrun),
    .err_cnt_o(err_cnt), .active_o(active), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_error = e;
    rx_done  = 1'b1;
    tick();
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_to;
    rst = 1'b1; go = 0; halt = 0; rx_busy = 0; rx_done = 0; rx_error = 0;
    rd_en = 0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx_en", rx_en, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overrun", overrun, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_active", active, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // single good byte
    go = 1; tick(); go = 0;
    chk("arm_active", active, 1);
    tick();
    chk("rx_en_2cyc", rx_en, 1);
    frame(8'hAA, 0);
    chk("aa_empty", empty, 0);
    chk("aa_count", count, 1);
    chk("aa_rd_data", rd_data, 8'hAA);
    rd_en = 1; tick(); rd_en = 0;
    chk("pop_empty", empty, 1);
    chk("pop_count", count, 0);
    chk("pop_hold", rd_data, 8'hAA);
    rd_en = 1; tick(); rd_en = 0;
    chk("pop_on_empty_count", count, 0);
    chk("pop_on_empty_hold", rd_data, 8'hAA);

    // overfill
    for (int i = 1; i <= 5; i++) frame(8'(i), 0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 4);
    chk("ovf_overrun", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_pop_data", rd_data, 8'(i));
      rd_en = 1; tick(); rd_en = 0;
    end
    chk("ovf_drained", empty, 1);

    // halt idle, restart clears overrun, then push+pop while full
    halt = 1; tick(); halt = 0;
    chk("halt_rx_en", rx_en, 0);
    chk("halt_active", active, 0);
    go = 1; tick(); go = 0;
    chk("go_clears_overrun", overrun, 0);
    tick();
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 0);
    chk("fill_full", full, 1);
    rd_en = 1;
    frame(8'h14, 0);
    rd_en = 0;
    chk("pp_count", count, 4);
    chk("pp_overrun", overrun, 0);
    chk("pp_full", full, 1);
    chk("pp_head", rd_data, 8'h11);
    for (int i = 1; i <= 4; i++) begin
      chk("pp_pop_data", rd_data, 8'h10 + 8'(i));
      rd_en = 1; tick(); rd_en = 0;
    end
    chk("pp_drained", empty, 1);

    // framing errors saturate
    frame(8'h00, 1);
    chk("err_one", err_cnt, 1);
    repeat (259) frame(8'hE7, 1);
    chk("err_sat", err_cnt, 8'hFF);
    chk("err_empty", empty, 1);
    chk("err_no_overrun", overrun, 0);

    // ignored events in IDLE
    halt = 1; tick(); halt = 0;
    frame(8'h77, 0);
    chk("idle_done_ignored", empty, 1);
    halt = 1; tick(); halt = 0;
    chk("idle_halt_ignored", active, 0);
    go = 1; halt = 1; tick(); go = 0; halt = 0;
    chk("go_halt_halt_wins", active, 0);
    chk("go_halt_no_clear", err_cnt, 8'hFF);

    // drain on halt mid-frame, rx_done in ARM ignored
    go = 1; tick(); go = 0;
    chk("go_clears_err", err_cnt, 0);
    frame(8'h99, 0);
    chk("arm_done_ignored", empty, 1);
    rx_busy = 1; halt = 1; tick(); halt = 0;
    chk("drain_rx_en", rx_en, 1);
    chk("drain_active", active, 1);
    tick();
    chk("drain_wait", active, 1);
    rx_busy = 0;
    frame(8'h3C, 0);
    chk("drain_count", count, 1);
    chk("drain_data", rd_data, 8'h3C);
    chk("drain_rx_en_off", rx_en, 0);
    chk("drain_idle", active, 0);

    // reset mid-frame
    go = 1; tick(); go = 0; tick();
    rx_busy = 1;
    frame(8'h5A, 0);
    chk("pre_rst_count", count, 2);
    rx_data = 8'hC3; rx_done = 1;
    #2 rst = 1;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_rx_en", rx_en, 0);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    tick();
    rx_done = 0; rx_busy = 0; rst = 0;
    tick();
    chk("post_rst_empty", empty, 1);

    // idle timeout
    go = 1; tick(); go = 0; tick();
    for (int k = 1; k <= 45; k++) begin
      tick();
`ifdef UART_RX_CTRL_TIMEOUT_EN
      exp_to = (k == 20 || k == 40);
`else
      exp_to = 1'b0;
`endif
      chk("timeout", timeout, exp_to);
    end
    chk("timeout_state_kept", active, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, receive buffer depth in bytes (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, 1600, idle clocks before timeout pulse (only with UART_RX_CTRL_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 go  input  1  one-cycle pulse to start reception.
REQ-006 halt  input  1  one-cycle pulse to stop reception.
REQ-007 rx_en  output  1  enable to the UART receiver.
REQ-008 rx_busy  input  1  receiver mid-frame.
REQ-009 rx_done  input  1  one-cycle frame-complete strobe from the receiver.
REQ-010 rx_error  input  1  framing error, qualified by rx_done.
REQ-011 rx_data  input  8  received byte, valid with rx_done.
REQ-012 rd_en  input  1  pop request from the consumer.
REQ-013 rd_data  output  8  FIFO head, first-word-fall-through.
REQ-014 empty  output  1  FIFO holds zero bytes.
REQ-015 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-016 count  output  $clog2(FIFO_DEPTH)+1  bytes held.
REQ-017 overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
REQ-018 err_cnt  output  8  framing-error count, saturating.
REQ-019 active  output  1  high in ARM, LISTEN or DRAIN.
REQ-020 timeout  output  1  one-cycle idle-timeout pulse.

Function
REQ-021 FSM states SHALL be IDLE, ARM, LISTEN and DRAIN, all registered.
REQ-022 IDLE: rx_en=0; go -> ARM; halt ignored.
REQ-023 ARM: rx_en=1 for exactly one cycle, then -> LISTEN unconditionally.
REQ-024 LISTEN: rx_en=1; on halt, -> IDLE if rx_busy=0, else -> DRAIN.
REQ-025 DRAIN: rx_en=1 until rx_done, process that frame per REQ-026/027 in the same cycle, then -> IDLE.
REQ-026 rx_done & !rx_error in LISTEN/DRAIN: push rx_data if not full; if full, drop it and set overrun.
REQ-027 rx_done & rx_error: drop the byte; err_cnt += 1, saturating at 255.
REQ-028 rx_done in IDLE or ARM SHALL be ignored.
REQ-029 rd_en & !empty pops one byte; rd_en while empty has no effect, and rd_data holds its value.
REQ-030 Simultaneous push and pop while full: both succeed, count unchanged, overrun not set.
REQ-031 Simultaneous push and pop while empty: the push succeeds and the pop is ignored.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL update in the cycle after the push/pop edge.
REQ-033 overrun and err_cnt clear only on reset or on a go accepted in IDLE.
REQ-034 go and halt in the same cycle: halt wins; go in a non-IDLE state is ignored.

Reset
REQ-035 On rst: state=IDLE, rx_en=0, FIFO empty (empty=1, full=0, count=0).
REQ-036 On rst: rd_data=8'h00, overrun=0, err_cnt=0, active=0, timeout=0, and all counters cleared.
REQ-037 rst asserted mid-frame SHALL abort immediately; no partial byte is stored.

Configuration
REQ-038 With UART_RX_CTRL_TIMEOUT_EN defined: in LISTEN, an idle counter increments each cycle while rx_busy=0.
REQ-039 The idle counter clears on rx_busy=1 or on leaving LISTEN.
REQ-040 When the idle counter reaches TIMEOUT_CYCLES-1, timeout pulses for one cycle and the counter restarts at 0; the state is unchanged.
REQ-041 Without UART_RX_CTRL_TIMEOUT_EN: timeout is tied to 0, no counter logic exists, and TIMEOUT_CYCLES is unused.

Verification
REQ-042 Reset, go, receive 8'hAA with no error -> rx_en=1 two cycles after go; empty=0, count=1, rd_data=8'hAA after rx_done.
REQ-043 Five good bytes 8'h01..8'h05 with FIFO_DEPTH=4 and no reads -> full=1, count=4, overrun=1; pops return 8'h01..8'h04.
REQ-044 rx_done with rx_error, repeated 260 times -> err_cnt=255, FIFO stays empty.
REQ-045 halt while rx_busy=1, then rx_done with 8'h3C -> state DRAIN, byte stored, then IDLE and rx_en=0.
REQ-046 FIFO full with rd_en and good rx_done in the same cycle -> count stays 4, overrun stays 0, head advances.
REQ-047 With the macro and TIMEOUT_CYCLES=20: LISTEN with rx_busy=0 -> timeout pulses at cycles 20 and 40 after entering LISTEN; without the macro, timeout stays 0.
